fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
MIPS instruction-fetch stage plus IF/ID pipeline register; directly upstream of the control unit, which decodes id_op.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Captures returned instructions into the IF/ID register.
- Handles hazard-unit stall/flush and branch/jump redirects, including redirects that arrive while a memory read is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width (fixed 32 for this core)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
imem_req  out  1  instruction read request
imem_addr  out  32  word address (byte addr, [1:0]=0)
imem_ack  in  1  read complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
stall  in  1  hazard unit: hold IF/ID register and PC
flush  in  1  hazard unit: squash IF/ID contents to bubble
branch_taken  in  1  redirect to branch_target
branch_target  in  32  branch destination
jump  in  1  redirect to jump target
jump_index  in  26  j-type instr_index
pc  out  32  current fetch PC
id_valid  out  1  IF/ID holds a live instruction
id_instr  out  32  IF/ID instruction (32'h0 = NOP when invalid)
id_op  out  6  id_instr[31:26], feeds control unit
id_pc_plus4  out  32  PC+4 of the IF/ID instruction

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_FETCH.
  - id_valid=0, id_instr=0, id_pc_plus4=0.
  - imem_req=0 while in reset; imem_req=1 from the first cycle after deassertion.
- Memory protocol:
  - imem_req stays high with imem_addr stable until the ack cycle; a request is never withdrawn.
  - Zero-wait ack (same cycle as req) is legal.
- Redirect:
  - redirect = branch_taken | jump. branch_taken has priority when both are asserted.
  - Jump target = {id_pc_plus4[31:28], jump_index, 2'b00}.
  - All PC arithmetic is modulo 2^32; PC+4 wraps 32'hFFFF_FFFC -> 0.
- Flush clears the IF/ID register (id_valid=0, id_instr=0) next edge and has priority over stall. A redirect does not itself clear IF/ID; the hazard unit asserts flush alongside.
- S_FETCH (imem_req=1, imem_addr=pc):
  - ack & redirect: discard rdata; pc<=target; stay.
  - ack & !stall: IF/ID<={1, rdata, pc+4}; pc<=pc+4; stay.
  - ack & stall: rdata -> skid buffer (instr, pc+4); pc<=pc+4; go S_HOLD.
  - !ack & redirect: save target in pend_pc; go S_DROP.
  - !ack & !stall: id_valid<=0 (bubble).
  - !ack & stall: IF/ID holds.
- S_HOLD (imem_req=0):
  - redirect: drop skid; pc<=target; go S_FETCH.
  - !stall: IF/ID<=skid; go S_FETCH.
  - else: hold.
- S_DROP (imem_req=1, imem_addr = old pc held stable):
  - A further redirect overwrites pend_pc (latest wins).
  - On ack: discard rdata; pc<=pend_pc (or the new target if redirect is asserted that cycle); go S_FETCH.
- id_op is combinational from id_instr.
- pc output reflects the next address to fetch. In S_DROP it shows the abandoned address until the ack.
- At most one outstanding memory request; skid depth is 1.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE 6'h00, OP_J 6'h02, OP_BEQ 6'h04, OP_ADDI 6'h08, OP_LW 6'h23, OP_SW 6'h2B)
  - NOP_INSTR 32'h0
  - default RESET_PC
  - fetch state encoding (S_FETCH, S_HOLD, S_DROP)
- One natural sub-module: if_id_reg. It holds valid/instr/pc_plus4 with load/hold/flush priority flush > stall > load; fetch_stage keeps the FSM, PC and skid.

Test Plan:
- Reset then zero-wait ack with rdata 0x2008_0005, 0x8C09_0000 -> imem_addr 0x0, 0x4; id_instr 0x2008_0005 (id_op 0x08), then 0x8C09_0000 (id_op 0x23); id_pc_plus4 4, 8.
- Ack with 2-cycle latency -> imem_addr held stable; id_valid=0 bubbles during the wait; pc advances only on the ack cycle.
- stall=1 during ack at pc 0x10 -> S_HOLD, imem_req=0, IF/ID unchanged; stall deasserted -> id_instr=buffered word, id_pc_plus4=0x14, next fetch 0x14.
- branch_taken with target 0x40 while ack pending at 0x20 -> S_DROP, addr 0x20 held; late ack data discarded; next imem_addr 0x40; no instruction from 0x20 appears in IF/ID.
- jump with jump_index 0x000_0010, id_pc_plus4 0x1000_0008 -> next fetch 0x1000_0040. Simultaneous branch_taken with target 0x80 -> fetch 0x80.
- flush & stall together -> id_valid=0, id_instr=0 next edge. Reset asserted mid-wait (S_DROP) -> immediately pc=RESET_PC, id_valid=0, imem_req=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, reset default and fetch FSM encoding
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [31:0] NOP_INSTR    = 32'h0;
    localparam logic [31:0] DEF_RESET_PC = 32'h0;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_t;

    function automatic logic [5:0] opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read handshake
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register, priority flush > stall > load
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        ld_valid,
    input  logic [31:0] ld_instr,
    input  logic [31:0] ld_pc4,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4
);
    // Bubbles keep id_pc_plus4 so a later jump still sees the last real PC+4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_pc_plus4 <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (!stall) begin
            id_valid <= ld_valid;
            id_instr <= ld_valid ? ld_instr : NOP_INSTR;
            if (ld_valid)
                id_pc_plus4 <= ld_pc4;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS PC/fetch FSM with skid buffer and redirect handling feeding IF/ID
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    output logic [ADDR_W-1:0]  pc,
    output logic               id_valid,
    output logic [31:0]        id_instr,
    output logic [5:0]         id_op,
    output logic [ADDR_W-1:0]  id_pc_plus4
);
    fetch_state_t state, state_nx;
    logic              redirect, ld_valid;
    logic [ADDR_W-1:0] tgt, pc_plus4, pend_pc, skid_pc4, ld_pc4;
    logic [31:0]       skid_instr, ld_instr;

    assign redirect = branch_taken | jump;
    assign tgt      = branch_taken ? branch_target : {id_pc_plus4[31:28], jump_index, 2'b00};
    assign pc_plus4 = pc + 32'd4;
    assign id_op    = opcode(id_instr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_FETCH;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: state_nx = imem.imem_ack ? ((stall && !redirect) ? S_HOLD : S_FETCH)
                                              : (redirect ? S_DROP : S_FETCH);
            S_HOLD:  state_nx = (redirect || !stall) ? S_FETCH : S_HOLD;
            S_DROP:  state_nx = imem.imem_ack ? S_FETCH : S_DROP;
            default: state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        imem.imem_req  = rst_n && (state != S_HOLD);
        imem.imem_addr = pc;
        ld_valid = (state == S_FETCH) ? (imem.imem_ack && !redirect)
                 : (state == S_HOLD)  ? !redirect : 1'b0;
        ld_instr = (state == S_HOLD) ? skid_instr : imem.imem_rdata;
        ld_pc4   = (state == S_HOLD) ? skid_pc4 : pc_plus4;
    end

    // pc only moves on an ack or out of HOLD; DROP keeps the abandoned address on the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            pend_pc    <= RESET_PC;
            skid_instr <= NOP_INSTR;
            skid_pc4   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        pc <= redirect ? tgt : pc_plus4;
                        if (stall && !redirect) begin
                            skid_instr <= imem.imem_rdata;
                            skid_pc4   <= pc_plus4;
                        end
                    end else if (redirect) begin
                        pend_pc <= tgt;
                    end
                end
                S_HOLD: if (redirect) pc <= tgt;
                S_DROP: begin
                    if (imem.imem_ack)
                        pc <= redirect ? tgt : pend_pc;
                    else if (redirect)
                        pend_pc <= tgt;
                end
                default: ;
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .stall       (stall),
        .ld_valid    (ld_valid),
        .ld_instr    (ld_instr),
        .ld_pc4      (ld_pc4),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc_plus4 (id_pc_plus4)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard monitor on the IF/ID register
module tb_fetch_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, branch_taken, jump;
    logic [31:0] branch_target, pc, id_instr, id_pc_plus4;
    logic [25:0] jump_index;
    logic        id_valid;
    logic [5:0]  id_op;

    fetch_stage_if imem();

    fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .pc            (pc),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_op         (id_op),
        .id_pc_plus4   (id_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    logic held = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] instr, input logic [31:0] pc4);
        sb.push_back('{op, instr, pc4});
    endtask

    task automatic fchk(input logic [31:0] addr, input logic req);
        chk("pc", pc, addr);
        chk("imem_addr", imem.imem_addr, addr);
        chk("imem_req", 32'(imem.imem_req), 32'(req));
    endtask

    // A new IF/ID load is any valid word after an edge that was neither stalled nor flushed
    always @(negedge clk) begin
        if (rst_n && id_valid && !held) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL id_unexpected: got instr %h pc4 %h expected none", id_instr, id_pc_plus4);
            end else begin
                mon_e = sb.pop_front();
                chk("id_instr", id_instr, mon_e.instr);
                chk("id_op", 32'(id_op), 32'(mon_e.op));
                chk("id_pc_plus4", id_pc_plus4, mon_e.pc4);
            end
        end
        held = stall | flush | !rst_n;
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_index = '0;
        imem.imem_ack = 1'b0; imem.imem_rdata = '0;
        #3;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem.imem_req), 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc4", id_pc_plus4, 32'h0);
        step; step;
        rst_n = 1'b1;
        #1;
        fchk(32'h0, 1'b1);

        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'h2008_0005; push(OP_ADDI, 32'h2008_0005, 32'h4);
        step; fchk(32'h4, 1'b1);
        imem.imem_rdata = 32'h8C09_0000; push(OP_LW, 32'h8C09_0000, 32'h8);
        step; fchk(32'h8, 1'b1);

        imem.imem_ack = 1'b0;
        repeat (2) begin
            step; fchk(32'h8, 1'b1);
            chk("wait_bubble", 32'(id_valid), 32'h0);
        end
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'h012A_4020; push(OP_RTYPE, 32'h012A_4020, 32'hC);
        step; fchk(32'hC, 1'b1);
        imem.imem_rdata = 32'h1109_0003; push(OP_BEQ, 32'h1109_0003, 32'h10);
        step; fchk(32'h10, 1'b1);

        stall = 1'b1;
        imem.imem_rdata = 32'hAD09_0004;
        step; fchk(32'h14, 1'b0);
        chk("hold_id_instr", id_instr, 32'h1109_0003);
        imem.imem_ack = 1'b0;
        step; fchk(32'h14, 1'b0);
        chk("hold_id_instr2", id_instr, 32'h1109_0003);
        chk("hold_id_pc4", id_pc_plus4, 32'h10);
        stall = 1'b0; push(OP_SW, 32'hAD09_0004, 32'h14);
        step; fchk(32'h14, 1'b1);

        imem.imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            imem.imem_rdata = 32'h2000_0000 + 32'(k);
            push(OP_ADDI, 32'h2000_0000 + 32'(k), 32'h18 + 32'(4 * k));
            step; fchk(32'h18 + 32'(4 * k), 1'b1);
        end

        imem.imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
        step; fchk(32'h20, 1'b1);
        branch_taken = 1'b0;
        step; fchk(32'h20, 1'b1);
        chk("drop_bubble", 32'(id_valid), 32'h0);
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
        step; fchk(32'h40, 1'b1);

        branch_taken = 1'b1; branch_target = 32'h1000_0004; imem.imem_rdata = 32'hFFFF_FFFF;
        step; fchk(32'h1000_0004, 1'b1);
        chk("redir_bubble", 32'(id_valid), 32'h0);
        branch_taken = 1'b0;
        imem.imem_rdata = 32'h0800_0010; push(OP_J, 32'h0800_0010, 32'h1000_0008);
        step; fchk(32'h1000_0008, 1'b1);
        jump = 1'b1; jump_index = 26'h10;
        step; fchk(32'h1000_0040, 1'b1);
        branch_taken = 1'b1; branch_target = 32'h80;
        step; fchk(32'h80, 1'b1);
        branch_taken = 1'b0; jump = 1'b0;
        imem.imem_rdata = 32'h8C0A_0008; push(OP_LW, 32'h8C0A_0008, 32'h84);
        step; fchk(32'h84, 1'b1);

        imem.imem_ack = 1'b0; flush = 1'b1; stall = 1'b1;
        step;
        chk("flush_id_valid", 32'(id_valid), 32'h0);
        chk("flush_id_instr", id_instr, 32'h0);
        chk("flush_pc", pc, 32'h84);
        flush = 1'b0; stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
        step; fchk(32'h84, 1'b1);
        branch_taken = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_id_valid", 32'(id_valid), 32'h0);
        chk("mid_rst_req", 32'(imem.imem_req), 32'h0);
        chk("mid_rst_id_instr", id_instr, 32'h0);
        step;
        rst_n = 1'b1;
        #1;
        fchk(32'h0, 1'b1);
        step; step;
        fchk(32'h0, 1'b1);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
